// File: rtl/pwr_axi_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : pwr_axi_wr_arb
// Purpose  : Serialises maestro and fsm single-word writes onto one AXI-Lite
//            AW/W/B channel. Optional macro PWR_WR_ARB_RR_EN: round-robin ties.
// Revision : 1.0 - initial release
// ============================================================================
module pwr_axi_wr_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] maestro_adress_i,
   input  logic [DATA_W-1:0] maestro_data_i,
   input  logic              maestro_req_i,
   output logic              maestro_valid_o,
   output logic              maestro_ack_o,
   input  logic [ADDR_W-1:0] fsm_adress_i,
   input  logic [DATA_W-1:0] fsm_data_i,
   input  logic              fsm_req_i,
   output logic              fsm_valid_o,
   output logic              fsm_ack_o,
   output logic [ADDR_W-1:0] aw_addr,
   output logic [2:0]        aw_prot,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [3:0]        w_strb,
   output logic              w_valid,
   input  logic              w_ready,
   input  logic [1:0]        b_resp,
   input  logic              b_valid,
   output logic              b_ready,
   output logic              err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_owner_fsm;
   logic [ADDR_W-1:0] r_aw_addr;
   logic [DATA_W-1:0] r_w_data;
   logic              r_aw_valid;
   logic              r_w_valid;
   logic              r_b_ready;
   logic              r_valid_m;
   logic              r_valid_f;
   logic              r_ack_m;
   logic              r_ack_f;
   logic              r_err;
   logic              r_armed_m;
   logic              r_armed_f;

   logic              w_elig_m;
   logic              w_elig_f;
   logic              w_grant;
   logic              w_pick_fsm;
   logic              w_addr_done;

   assign w_elig_m = maestro_req_i & r_armed_m;
   assign w_elig_f = fsm_req_i & r_armed_f;
   assign w_grant  = w_elig_m | w_elig_f;

`ifdef PWR_WR_ARB_RR_EN
   // Reset to "fsm granted last" so that maestro wins the first tie.
   logic r_last_fsm;
   assign w_pick_fsm = w_elig_f & (~w_elig_m | ~r_last_fsm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_fsm <= 1'b1;
      end else if (r_state == ST_IDLE && w_grant) begin
         r_last_fsm <= w_pick_fsm;
      end
   end
`else
   assign w_pick_fsm = w_elig_f & ~w_elig_m;
`endif

   // Both AW and W handshakes are finished once this edge passes.
   assign w_addr_done = (~r_aw_valid | aw_ready) & (~r_w_valid | w_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_owner_fsm <= 1'b0;
         r_aw_addr   <= '0;
         r_w_data    <= '0;
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_b_ready   <= 1'b0;
         r_valid_m   <= 1'b0;
         r_valid_f   <= 1'b0;
         r_ack_m     <= 1'b0;
         r_ack_f     <= 1'b0;
         r_err       <= 1'b0;
         r_armed_m   <= 1'b1;
         r_armed_f   <= 1'b1;
      end else begin
         // A low req re-arms even in the ack cycle; a held req is disarmed.
         if (!maestro_req_i) begin
            r_armed_m <= 1'b1;
         end else if (r_ack_m) begin
            r_armed_m <= 1'b0;
         end
         if (!fsm_req_i) begin
            r_armed_f <= 1'b1;
         end else if (r_ack_f) begin
            r_armed_f <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_owner_fsm <= w_pick_fsm;
                  r_aw_addr   <= w_pick_fsm ? fsm_adress_i : maestro_adress_i;
                  r_w_data    <= w_pick_fsm ? fsm_data_i : maestro_data_i;
                  r_aw_valid  <= 1'b1;
                  r_w_valid   <= 1'b1;
                  r_valid_m   <= ~w_pick_fsm;
                  r_valid_f   <= w_pick_fsm;
                  r_state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (aw_ready) begin
                  r_aw_valid <= 1'b0;
               end
               if (w_ready) begin
                  r_w_valid <= 1'b0;
               end
               if (w_addr_done) begin
                  r_b_ready <= 1'b1;
                  r_state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (b_valid) begin
                  r_b_ready <= 1'b0;
                  if (b_resp != 2'b00) begin
                     r_err <= 1'b1;
                  end
                  r_ack_m <= ~r_owner_fsm;
                  r_ack_f <= r_owner_fsm;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               r_ack_m   <= 1'b0;
               r_ack_f   <= 1'b0;
               r_valid_m <= 1'b0;
               r_valid_f <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign aw_addr         = r_aw_addr;
   assign aw_prot         = 3'b000;
   assign aw_valid        = r_aw_valid;
   assign w_data          = r_w_data;
   assign w_strb          = 4'hF;
   assign w_valid         = r_w_valid;
   assign b_ready         = r_b_ready;
   assign maestro_valid_o = r_valid_m;
   assign maestro_ack_o   = r_ack_m;
   assign fsm_valid_o     = r_valid_f;
   assign fsm_ack_o       = r_ack_f;
   assign err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pwr_axi_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_axi_wr_arb
// Purpose  : Self-checking bench for pwr_axi_wr_arb: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwr_axi_wr_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] maestro_adress_i = '0;
   logic [31:0] maestro_data_i = '0;
   logic        maestro_req_i = 1'b0;
   logic        maestro_valid_o;
   logic        maestro_ack_o;
   logic [31:0] fsm_adress_i = '0;
   logic [31:0] fsm_data_i = '0;
   logic        fsm_req_i = 1'b0;
   logic        fsm_valid_o;
   logic        fsm_ack_o;
   logic [31:0] aw_addr;
   logic [2:0]  aw_prot;
   logic        aw_valid;
   logic        aw_ready = 1'b0;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [1:0]  b_resp = 2'b00;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic        err_o;

   pwr_axi_wr_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .maestro_adress_i(maestro_adress_i), .maestro_data_i(maestro_data_i),
      .maestro_req_i(maestro_req_i), .maestro_valid_o(maestro_valid_o),
      .maestro_ack_o(maestro_ack_o),
      .fsm_adress_i(fsm_adress_i), .fsm_data_i(fsm_data_i),
      .fsm_req_i(fsm_req_i), .fsm_valid_o(fsm_valid_o), .fsm_ack_o(fsm_ack_o),
      .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one outstanding write described by completion flags.
   bit          m_busy = 0, m_owner = 0, m_aw_done = 0, m_w_done = 0, m_b_done = 0;
   bit          m_ack = 0, m_err = 0, m_last_fsm = 1;
   bit  [1:0]   m_armed = 2'b11;
   logic [31:0] m_addr = '0, m_data = '0;

   always @(posedge clk or negedge rst_n) begin
      bit [1:0] rq;
      bit [1:0] el;
      bit       pick;
      bit       resp_phase;
      if (!rst_n) begin
         m_busy = 0; m_owner = 0; m_aw_done = 0; m_w_done = 0; m_b_done = 0;
         m_ack = 0; m_err = 0; m_last_fsm = 1; m_armed = 2'b11;
         m_addr = '0; m_data = '0;
      end else begin
         rq = {fsm_req_i, maestro_req_i};
         el = rq & m_armed;
         for (int ch = 0; ch < 2; ch++) begin
            if (!rq[ch]) m_armed[ch] = 1'b1;
            else if (m_ack && (m_owner == ch[0])) m_armed[ch] = 1'b0;
         end
         if (m_ack) begin
            m_ack  = 0;
            m_busy = 0;
         end else if (!m_busy) begin
            if (el != 2'b00) begin
               if (el == 2'b11) begin
`ifdef PWR_WR_ARB_RR_EN
                  pick = ~m_last_fsm;
`else
                  pick = 1'b0;
`endif
               end else begin
                  pick = el[1];
               end
               m_busy = 1; m_owner = pick; m_last_fsm = pick;
               m_addr = pick ? fsm_adress_i : maestro_adress_i;
               m_data = pick ? fsm_data_i : maestro_data_i;
               m_aw_done = 0; m_w_done = 0; m_b_done = 0;
            end
         end else begin
            resp_phase = m_aw_done && m_w_done && !m_b_done;
            if (resp_phase && b_valid) begin
               m_b_done = 1;
               m_ack    = 1;
               if (b_resp != 2'b00) m_err = 1;
            end
            if (!m_aw_done && aw_ready) m_aw_done = 1;
            if (!m_w_done && w_ready) m_w_done = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("mon_aw_valid", aw_valid, m_busy && !m_aw_done);
         check_eq("mon_w_valid", w_valid, m_busy && !m_w_done);
         check_eq("mon_b_ready", b_ready, m_busy && m_aw_done && m_w_done && !m_b_done);
         check_eq("mon_m_valid", maestro_valid_o, m_busy && !m_owner);
         check_eq("mon_f_valid", fsm_valid_o, m_busy && m_owner);
         check_eq("mon_m_ack", maestro_ack_o, m_ack && !m_owner);
         check_eq("mon_f_ack", fsm_ack_o, m_ack && m_owner);
         check_eq("mon_err", err_o, m_err);
         check_eq("mon_aw_addr", aw_addr, m_addr);
         check_eq("mon_w_data", w_data, m_data);
         check_eq("mon_w_strb", w_strb, 4'hF);
         check_eq("mon_aw_prot", aw_prot, 3'b000);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_idle();
      aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
   endtask

   task automatic set_req(input bit ch, input bit v);
      if (ch) fsm_req_i = v;
      else maestro_req_i = v;
   endtask

   // One write with slave delays; cycle N is the cycle this task is entered.
   task automatic do_write(input bit ch, input logic [31:0] a, input logic [31:0] d,
                           input int awd, input int wd, input int bd, input logic [1:0] resp);
      int hs;
      int exp_ack;
      int acks;
      int ack_at;
      hs = (awd > wd) ? awd : wd;
      exp_ack = 3 + hs + bd;
      acks = 0;
      ack_at = -1;
      if (ch) begin fsm_adress_i = a; fsm_data_i = d; end
      else begin maestro_adress_i = a; maestro_data_i = d; end
      set_req(ch, 1'b1);
      for (int k = 1; k <= exp_ack + 3; k++) begin
         tick();
         aw_ready = (k == 1 + awd);
         w_ready  = (k == 1 + wd);
         b_valid  = (k == 2 + hs + bd);
         b_resp   = b_valid ? resp : 2'b00;
         if (k == 1) begin
            check_eq("wr_aw_addr", aw_addr, a);
            check_eq("wr_w_data", w_data, d);
            check_eq("wr_w_strb", w_strb, 4'hF);
         end
         if (k <= hs + 1) begin
            check_eq("wr_aw_valid", aw_valid, k <= 1 + awd);
            check_eq("wr_w_valid", w_valid, k <= 1 + wd);
         end
         if (k == 2 + hs) check_eq("wr_b_ready", b_ready, 1);
         if ((ch ? fsm_ack_o : maestro_ack_o) === 1'b1) begin
            acks++;
            ack_at = k;
            set_req(ch, 1'b0);
         end
      end
      set_req(ch, 1'b0);
      slave_idle();
      check_eq("wr_ack_cycle", ack_at, exp_ack);
      check_eq("wr_ack_count", acks, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      maestro_req_i = 0; fsm_req_i = 0;
      aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
      for (int k = 0; k < 40 && !ok; k++) begin
         tick();
         if (!maestro_valid_o && !fsm_valid_o) ok = 1;
      end
      slave_idle();
      check_eq("idle_reached", ok, 1);
   endtask

   initial begin
      int ord[3];
      int n_ord;
      bit pend_m, pend_f;
      bit got;
      int acks;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_aw_valid", aw_valid, 0);
      check_eq("rst_b_ready", b_ready, 0);
      check_eq("rst_m_ack", maestro_ack_o, 0);
      check_eq("rst_aw_addr", aw_addr, 0);
      check_eq("rst_err", err_o, 0);
      chk_en = 1;
      rst_n = 1;
      tick();

      // Single maestro write, zero-wait; skewed AW/W; delayed B.
      do_write(1'b0, 32'h0000_0014, 32'h2, 0, 0, 0, 2'b00);
      do_write(1'b0, 32'h0000_0020, 32'hA5A5_0001, 3, 0, 0, 2'b00);
      do_write(1'b0, 32'h0000_0024, 32'h1234_5678, 0, 0, 5, 2'b00);

      // SLVERR on fsm write; error stays sticky across OKAY writes.
      check_eq("err_before", err_o, 0);
      do_write(1'b1, 32'h4000_0100, 32'hDEAD_BEEF, 0, 0, 0, 2'b10);
      check_eq("err_set", err_o, 1);
      do_write(1'b0, 32'h0000_0028, 32'h7, 1, 2, 1, 2'b00);
      check_eq("err_sticky", err_o, 1);

      // Req held past ack is not re-granted until it drops for a cycle.
      maestro_adress_i = 32'h30; maestro_data_i = 32'h3;
      maestro_req_i = 1;
      aw_ready = 1; w_ready = 1; b_valid = 1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 3) check_eq("hold_ack", maestro_ack_o, 1);
         if (k >= 4 && k <= 7) check_eq("hold_no_regrant", maestro_valid_o, 0);
         if (k == 8) maestro_req_i = 0;
         if (k == 9) maestro_req_i = 1;
         if (k == 10) check_eq("rearm_grant", maestro_valid_o, 1);
      end
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (maestro_ack_o) begin got = 1; maestro_req_i = 0; end
      end
      check_eq("rearm_ack", got, 1);
      wait_idle();

      // Simultaneous requests held until acked.
      maestro_adress_i = 32'h40; maestro_data_i = 32'h4;
      fsm_adress_i = 32'h5000_0000; fsm_data_i = 32'h5;
      maestro_req_i = 1; fsm_req_i = 1;
      aw_ready = 1; w_ready = 1; b_valid = 1;
      ord = '{9, 9, 9};
      n_ord = 0;
      for (int k = 0; k < 30 && n_ord < 2; k++) begin
         tick();
         if (maestro_ack_o) begin ord[n_ord] = 0; n_ord++; maestro_req_i = 0; end
         if (fsm_ack_o && n_ord < 2) begin ord[n_ord] = 1; n_ord++; fsm_req_i = 0; end
      end
      check_eq("tie_held_first", ord[0], 0);
      check_eq("tie_held_second", ord[1], 1);
      wait_idle();

      // Back-to-back ties: each winner drops for one cycle then re-requests.
      maestro_req_i = 1; fsm_req_i = 1;
      aw_ready = 1; w_ready = 1; b_valid = 1;
      ord = '{9, 9, 9};
      n_ord = 0;
      pend_m = 0; pend_f = 0;
      for (int k = 0; k < 40 && n_ord < 3; k++) begin
         tick();
         if (pend_m) begin maestro_req_i = 1; pend_m = 0; end
         if (pend_f) begin fsm_req_i = 1; pend_f = 0; end
         if (maestro_ack_o) begin ord[n_ord] = 0; n_ord++; maestro_req_i = 0; pend_m = 1; end
         if (fsm_ack_o && n_ord < 3) begin ord[n_ord] = 1; n_ord++; fsm_req_i = 0; pend_f = 1; end
      end
      check_eq("tie_rr_first", ord[0], 0);
`ifdef PWR_WR_ARB_RR_EN
      check_eq("tie_rr_second", ord[1], 1);
`else
      check_eq("tie_rr_second", ord[1], 0);
`endif
      check_eq("tie_rr_third", ord[2], 0);
      wait_idle();

      // Asynchronous reset while AW is stalled.
      maestro_adress_i = 32'h60; maestro_data_i = 32'h6;
      maestro_req_i = 1;
      slave_idle();
      tick();
      tick();
      check_eq("pre_rst_aw_valid", aw_valid, 1);
      #1 rst_n = 0;
      #1;
      check_eq("arst_aw_valid", aw_valid, 0);
      check_eq("arst_w_valid", w_valid, 0);
      check_eq("arst_b_ready", b_ready, 0);
      check_eq("arst_m_valid", maestro_valid_o, 0);
      check_eq("arst_aw_addr", aw_addr, 0);
      check_eq("arst_w_data", w_data, 0);
      check_eq("arst_err", err_o, 0);
      maestro_req_i = 0;
      @(negedge clk);
      #1 rst_n = 1;
      acks = 0;
      aw_ready = 1; w_ready = 1; b_valid = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         acks += int'(maestro_ack_o | fsm_ack_o);
      end
      check_eq("no_ack_after_rst", acks, 0);
      slave_idle();

      // Randomized traffic; the monitor compares every cycle against the model.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         aw_ready = ($urandom % 4) != 0;
         w_ready  = ($urandom % 4) != 0;
         b_valid  = ($urandom % 3) != 0;
         b_resp   = (($urandom % 8) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
         if (maestro_req_i) begin
            if (maestro_ack_o ? (($urandom % 4) != 0) : (($urandom % 32) == 0)) maestro_req_i = 0;
         end else if (($urandom % 3) == 0) begin
            maestro_adress_i = $urandom; maestro_data_i = $urandom; maestro_req_i = 1;
         end
         if (fsm_req_i) begin
            if (fsm_ack_o ? (($urandom % 4) != 0) : (($urandom % 32) == 0)) fsm_req_i = 0;
         end else if (($urandom % 3) == 0) begin
            fsm_adress_i = $urandom; fsm_data_i = $urandom; fsm_req_i = 1;
         end
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
